irq_pending_ctrl: RTL and testbench

IRQ_PENDING_CTRL -- requirements
Module: irq_pending_ctrl

---
 rtl/irq_pending_ctrl.sv | 116 +++++++++++
 tb/tb_irq_pending_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/irq_pending_ctrl.sv
// Interrupt pending/mask controller: edge-captures eight request lines, tracks
// lost events, and presents one unmasked request at a time until acknowledged.
module irq_pending_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] irq_in,
    input  logic       mask_we,
    input  logic [7:0] mask_din,
    input  logic       irq_ack,
    input  logic       ovr_clr,
    output logic [7:0] req_vec,
    output logic       irq_valid,
    output logic [2:0] irq_id,
    output logic [7:0] overrun,
    output logic [7:0] mask
);

    localparam int unsigned NUM_IRQ = 8;
    localparam int unsigned ID_W    = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t               r_state;
    logic [NUM_IRQ-1:0]   r_irq_prev;
    logic [NUM_IRQ-1:0]   r_pending;
    logic [NUM_IRQ-1:0]   r_mask;
    logic [NUM_IRQ-1:0]   r_overrun;
    logic [NUM_IRQ-1:0]   r_req_vec;
    logic                 r_irq_valid;
    logic [ID_W-1:0]      r_irq_id;

    logic [NUM_IRQ-1:0]   w_event;
    logic [NUM_IRQ-1:0]   w_ack_clr;
    logic [NUM_IRQ-1:0]   w_ovr_set;
    logic [NUM_IRQ-1:0]   w_pending_nxt;
    logic [NUM_IRQ-1:0]   w_overrun_nxt;
    logic [NUM_IRQ-1:0]   w_mask_nxt;
    logic [NUM_IRQ-1:0]   w_eligible;
    logic [ID_W-1:0]      w_top_id;

    // Highest set index wins; bit 7 is the highest priority.
    function automatic logic [ID_W-1:0] f_prio(input logic [NUM_IRQ-1:0] v);
        logic [ID_W-1:0] id;
        id = '0;
        for (int i = 0; i < int'(NUM_IRQ); i++) begin
            if (v[i]) id = ID_W'(i);
        end
        return id;
    endfunction

    always_comb begin
        w_event   = irq_in & ~r_irq_prev;
        w_ack_clr = '0;
        if (r_state == PRESENT && irq_ack) begin
            w_ack_clr = NUM_IRQ'(1) << r_irq_id;
        end
        // An event landing on the line being acknowledged re-arms it without overrun.
        w_ovr_set     = w_event & r_pending & ~w_ack_clr;
        w_pending_nxt = (r_pending & ~w_ack_clr) | w_event;
        w_overrun_nxt = (ovr_clr ? '0 : r_overrun) | w_ovr_set;
        w_mask_nxt    = mask_we ? mask_din : r_mask;
        w_eligible    = r_pending & ~r_mask;
        w_top_id      = f_prio(w_eligible);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_irq_prev  <= '0;
            r_pending   <= '0;
            r_mask      <= '0;
            r_overrun   <= '0;
            r_req_vec   <= '0;
            r_irq_valid <= 1'b0;
            r_irq_id    <= '0;
        end else begin
            r_irq_prev <= irq_in;
            r_pending  <= w_pending_nxt;
            r_mask     <= w_mask_nxt;
            r_overrun  <= w_overrun_nxt;
            r_req_vec  <= w_pending_nxt & ~w_mask_nxt;
            case (r_state)
                IDLE: begin
                    if (w_eligible != '0) begin
                        r_irq_id    <= w_top_id;
                        r_irq_valid <= 1'b1;
                        r_state     <= PRESENT;
                    end else begin
                        r_irq_valid <= 1'b0;
                    end
                end
                PRESENT: begin
                    // No pre-emption: hold the presented id until acknowledged.
                    if (irq_ack) begin
                        r_irq_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_irq_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign req_vec   = r_req_vec;
    assign irq_valid = r_irq_valid;
    assign irq_id    = r_irq_id;
    assign overrun   = r_overrun;
    assign mask      = r_mask;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed bench for irq_pending_ctrl: expectations are queued with each
// stimulus step and compared against the outputs after the following edge.
module tb_irq_pending_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] irq_in;
    logic       mask_we;
    logic [7:0] mask_din;
    logic       irq_ack;
    logic       ovr_clr;
    logic [7:0] req_vec;
    logic       irq_valid;
    logic [2:0] irq_id;
    logic [7:0] overrun;
    logic [7:0] mask;

    typedef struct {
        string      tag;
        logic       valid;
        logic [2:0] id;
        logic [7:0] req;
        logic [7:0] ovr;
        logic [7:0] msk;
    } exp_t;

    exp_t sb_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    irq_pending_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .irq_in    (irq_in),
        .mask_we   (mask_we),
        .mask_din  (mask_din),
        .irq_ack   (irq_ack),
        .ovr_clr   (ovr_clr),
        .req_vec   (req_vec),
        .irq_valid (irq_valid),
        .irq_id    (irq_id),
        .overrun   (overrun),
        .mask      (mask)
    );

    always #5 clk = ~clk;

    // Queue the expectation, advance one edge, then pop and compare.
    task automatic step(input string tag, input logic v, input logic [2:0] id,
                        input logic [7:0] rq, input logic [7:0] ov, input logic [7:0] mk);
        exp_t e;
        e.tag = tag; e.valid = v; e.id = id; e.req = rq; e.ovr = ov; e.msk = mk;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        n_assert++;
        assert (sb_q.size() != 0) else begin
            n_fail++;
            $error("FAIL %s: scoreboard empty", tag);
        end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            n_assert++;
            assert (irq_valid === e.valid) else begin
                n_fail++;
                $error("FAIL %s irq_valid: got %b want %b", e.tag, irq_valid, e.valid);
            end
            if (e.valid) begin
                n_assert++;
                assert (irq_id === e.id) else begin
                    n_fail++;
                    $error("FAIL %s irq_id: got %0d want %0d", e.tag, irq_id, e.id);
                end
            end
            n_assert++;
            assert (req_vec === e.req) else begin
                n_fail++;
                $error("FAIL %s req_vec: got %h want %h", e.tag, req_vec, e.req);
            end
            n_assert++;
            assert (overrun === e.ovr) else begin
                n_fail++;
                $error("FAIL %s overrun: got %h want %h", e.tag, overrun, e.ovr);
            end
            n_assert++;
            assert (mask === e.msk) else begin
                n_fail++;
                $error("FAIL %s mask: got %h want %h", e.tag, mask, e.msk);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; irq_in = '0; mask_we = 1'b0; mask_din = '0; irq_ack = 1'b0; ovr_clr = 1'b0;
        @(posedge clk); #1;
        step("reset", 1'b0, 3'd0, 8'h00, 8'h00, 8'h00);
        rst = 1'b0;
        step("idle", 1'b0, 3'd0, 8'h00, 8'h00, 8'h00);

        // Single event on line 2
        irq_in = 8'h04;
        step("single_k", 1'b0, 3'd0, 8'h04, 8'h00, 8'h00);
        step("single_k1", 1'b1, 3'd2, 8'h04, 8'h00, 8'h00);
        irq_ack = 1'b1;
        step("single_ack", 1'b0, 3'd0, 8'h00, 8'h00, 8'h00);
        irq_ack = 1'b0; irq_in = 8'h00;
        step("single_done", 1'b0, 3'd0, 8'h00, 8'h00, 8'h00);

        // Priority 7 over 0; ack while idle is ignored
        irq_in = 8'h81; irq_ack = 1'b1;
        step("prio_k", 1'b0, 3'd0, 8'h81, 8'h00, 8'h00);
        irq_ack = 1'b0;
        step("prio_id7", 1'b1, 3'd7, 8'h81, 8'h00, 8'h00);
        irq_ack = 1'b1;
        step("prio_ack7", 1'b0, 3'd0, 8'h01, 8'h00, 8'h00);
        irq_ack = 1'b0;
        step("prio_id0", 1'b1, 3'd0, 8'h01, 8'h00, 8'h00);
        irq_ack = 1'b1;
        step("prio_ack0", 1'b0, 3'd0, 8'h00, 8'h00, 8'h00);
        irq_ack = 1'b0; irq_in = 8'h00;
        step("prio_done", 1'b0, 3'd0, 8'h00, 8'h00, 8'h00);

        // Masking line 7
        mask_we = 1'b1; mask_din = 8'h80;
        step("mask_wr", 1'b0, 3'd0, 8'h00, 8'h00, 8'h80);
        mask_we = 1'b0; irq_in = 8'h81;
        step("mask_k", 1'b0, 3'd0, 8'h01, 8'h00, 8'h80);
        step("mask_id0", 1'b1, 3'd0, 8'h01, 8'h00, 8'h80);
        irq_ack = 1'b1;
        step("mask_ack0", 1'b0, 3'd0, 8'h00, 8'h00, 8'h80);
        irq_ack = 1'b0; mask_we = 1'b1; mask_din = 8'h00;
        step("unmask_wr", 1'b0, 3'd0, 8'h80, 8'h00, 8'h00);
        mask_we = 1'b0;
        step("unmask_id7", 1'b1, 3'd7, 8'h80, 8'h00, 8'h00);
        irq_ack = 1'b1;
        step("unmask_ack", 1'b0, 3'd0, 8'h00, 8'h00, 8'h00);
        irq_ack = 1'b0; irq_in = 8'h00;
        step("mask_done", 1'b0, 3'd0, 8'h00, 8'h00, 8'h00);

        // Overrun on line 3
        irq_in = 8'h08;
        step("ovr_k", 1'b0, 3'd0, 8'h08, 8'h00, 8'h00);
        irq_in = 8'h00;
        step("ovr_id3", 1'b1, 3'd3, 8'h08, 8'h00, 8'h00);
        irq_in = 8'h08;
        step("ovr_set", 1'b1, 3'd3, 8'h08, 8'h08, 8'h00);
        irq_ack = 1'b1;
        step("ovr_ack", 1'b0, 3'd0, 8'h00, 8'h08, 8'h00);
        irq_ack = 1'b0;
        step("ovr_single", 1'b0, 3'd0, 8'h00, 8'h08, 8'h00);
        ovr_clr = 1'b1;
        step("ovr_clr", 1'b0, 3'd0, 8'h00, 8'h00, 8'h00);
        ovr_clr = 1'b0; irq_in = 8'h00;
        step("ovr_done", 1'b0, 3'd0, 8'h00, 8'h00, 8'h00);

        // Ack of id 5 coinciding with a new rise on line 5
        irq_in = 8'h20;
        step("coll_k", 1'b0, 3'd0, 8'h20, 8'h00, 8'h00);
        irq_in = 8'h00;
        step("coll_id5", 1'b1, 3'd5, 8'h20, 8'h00, 8'h00);
        irq_in = 8'h20; irq_ack = 1'b1;
        step("coll_ack", 1'b0, 3'd0, 8'h20, 8'h00, 8'h00);
        irq_ack = 1'b0;
        step("coll_repres", 1'b1, 3'd5, 8'h20, 8'h00, 8'h00);
        irq_ack = 1'b1;
        step("coll_ack2", 1'b0, 3'd0, 8'h00, 8'h00, 8'h00);
        irq_ack = 1'b0;
        step("coll_done", 1'b0, 3'd0, 8'h00, 8'h00, 8'h00);
        irq_in = 8'h00;
        step("coll_low", 1'b0, 3'd0, 8'h00, 8'h00, 8'h00);

        // Reset during presentation of id 6, line held high through release
        irq_in = 8'h40;
        step("rst_k", 1'b0, 3'd0, 8'h40, 8'h00, 8'h00);
        step("rst_id6", 1'b1, 3'd6, 8'h40, 8'h00, 8'h00);
        rst = 1'b1;
        step("rst_mid", 1'b0, 3'd0, 8'h00, 8'h00, 8'h00);
        rst = 1'b0;
        step("rst_rel", 1'b0, 3'd0, 8'h40, 8'h00, 8'h00);
        step("rst_repres", 1'b1, 3'd6, 8'h40, 8'h00, 8'h00);
        irq_ack = 1'b1;
        step("rst_ack", 1'b0, 3'd0, 8'h00, 8'h00, 8'h00);
        irq_ack = 1'b0;
        step("rst_no_event", 1'b0, 3'd0, 8'h00, 8'h00, 8'h00);
        step("rst_quiet", 1'b0, 3'd0, 8'h00, 8'h00, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
